// File: rtl/mccpu_ctrl.sv
// Multicycle control FSM for a shared-memory MIPS-subset datapath.
// Optional MCCPU_MEM_WAIT_EN adds a mem_ready handshake that stalls S_FETCH, S_MRD and S_MWR.
module mccpu_ctrl #(
    parameter int RESET_STATE_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef MCCPU_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       IorD,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       EXTOp,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0,  S_DCD = 4'd1,  S_EXE = 4'd2,  S_ALUWB = 4'd3,
        S_MADDR = 4'd4,  S_MRD = 4'd5,  S_MWB = 4'd6,  S_MWR   = 4'd7,
        S_BR    = 4'd8,  S_JMP = 4'd9,  S_JAL = 4'd10, S_NOP   = 4'd11,
        S_IDLE  = 4'd15
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR = 3'b100, ALU_SLT = 3'b101;
    localparam logic [3:0] HOLD_LAST = 4'(RESET_STATE_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       illegal_q, illegal_d;
    logic       mem_rdy;
    logic       is_rtype, r_ok;
    logic [2:0] r_aluop;

`ifdef MCCPU_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign is_rtype = (Op == OP_R);
    assign state    = state_q;
    assign illegal  = illegal_q;

    always_comb begin
        r_aluop = 3'b000;
        r_ok    = 1'b1;
        case (Funct)
            6'b100001: r_aluop = ALU_ADD;
            6'b100011: r_aluop = ALU_SUB;
            6'b100100: r_aluop = ALU_AND;
            6'b100101: r_aluop = ALU_OR;
            6'b101010: r_aluop = ALU_SLT;
            default:   r_ok    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hold_q    <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        illegal_d  = illegal_q;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        EXTOp      = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = 3'b000;
        NPCOp      = 2'b00;
        GPRSel     = 2'b00;
        WDSel      = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_FETCH;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            S_FETCH: begin
                IRWr = 1'b1;
                if (mem_rdy) state_d = S_DCD;
            end
            S_DCD: begin
                if ((is_rtype && r_ok) || Op == OP_ADDI || Op == OP_ORI) state_d = S_EXE;
                else if (Op == OP_LW || Op == OP_SW)                      state_d = S_MADDR;
                else if (Op == OP_BEQ)                                    state_d = S_BR;
                else if (Op == OP_J)                                      state_d = S_JMP;
                else if (Op == OP_JAL)                                    state_d = S_JAL;
                else begin
                    state_d   = S_NOP;
                    illegal_d = 1'b1;
                end
            end
            S_EXE: begin
                if (is_rtype) begin
                    ALUOp = r_aluop;
                end else if (Op == OP_ADDI) begin
                    ALUSrc = 1'b1;
                    EXTOp  = 1'b1;
                    ALUOp  = ALU_ADD;
                end else begin
                    ALUSrc = 1'b1;
                    ALUOp  = ALU_OR;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                GPRSel     = is_rtype ? 2'b00 : 2'b01;
                PCWr       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MADDR: begin
                ALUSrc  = 1'b1;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADD;
                state_d = (Op == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                IorD = 1'b1;
                if (mem_rdy) state_d = S_MWB;
            end
            S_MWB: begin
                RegWrite   = 1'b1;
                WDSel      = 2'b01;
                GPRSel     = 2'b01;
                PCWr       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MWR: begin
                // The store completes, and the PC moves on, only once memory accepts it.
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                PCWr       = mem_rdy;
                instr_done = mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_BR: begin
                ALUOp      = ALU_SUB;
                PCWr       = 1'b1;
                NPCOp      = Zero ? 2'b01 : 2'b00;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JMP: begin
                PCWr       = 1'b1;
                NPCOp      = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                RegWrite   = 1'b1;
                GPRSel     = 2'b10;
                WDSel      = 2'b10;
                PCWr       = 1'b1;
                NPCOp      = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_NOP: begin
                PCWr       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed-vector bench for mccpu_ctrl: per-cycle state and full control-word checks.
module tb_mccpu_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
`ifdef MCCPU_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       PCWr, IRWr, IorD, MemWrite, RegWrite, EXTOp, ALUSrc, instr_done, illegal;
    logic [2:0] ALUOp;
    logic [1:0] NPCOp, GPRSel, WDSel;
    logic [3:0] state;
    int checks = 0;
    int errors = 0;

    // {PCWr,IRWr,IorD,MemWrite,RegWrite,EXTOp,ALUSrc,ALUOp,NPCOp,GPRSel,WDSel,instr_done}
    wire [16:0] outs = {PCWr, IRWr, IorD, MemWrite, RegWrite, EXTOp, ALUSrc,
                        ALUOp, NPCOp, GPRSel, WDSel, instr_done};

    localparam logic [16:0] E_FE    = 17'b0_1_0_0_0_0_0_000_00_00_00_0;
    localparam logic [16:0] E_DCD   = 17'b0_0_0_0_0_0_0_000_00_00_00_0;
    localparam logic [16:0] E_ADDU  = 17'b0_0_0_0_0_0_0_001_00_00_00_0;
    localparam logic [16:0] E_SUBU  = 17'b0_0_0_0_0_0_0_010_00_00_00_0;
    localparam logic [16:0] E_AND   = 17'b0_0_0_0_0_0_0_011_00_00_00_0;
    localparam logic [16:0] E_OR    = 17'b0_0_0_0_0_0_0_100_00_00_00_0;
    localparam logic [16:0] E_SLT   = 17'b0_0_0_0_0_0_0_101_00_00_00_0;
    localparam logic [16:0] E_ADDI  = 17'b0_0_0_0_0_1_1_001_00_00_00_0;
    localparam logic [16:0] E_ORI   = 17'b0_0_0_0_0_0_1_100_00_00_00_0;
    localparam logic [16:0] E_WB_R  = 17'b1_0_0_0_1_0_0_000_00_00_00_1;
    localparam logic [16:0] E_WB_I  = 17'b1_0_0_0_1_0_0_000_00_01_00_1;
    localparam logic [16:0] E_MADDR = 17'b0_0_0_0_0_1_1_001_00_00_00_0;
    localparam logic [16:0] E_MRD   = 17'b0_0_1_0_0_0_0_000_00_00_00_0;
    localparam logic [16:0] E_MWB   = 17'b1_0_0_0_1_0_0_000_00_01_01_1;
    localparam logic [16:0] E_MWR   = 17'b1_0_1_1_0_0_0_000_00_00_00_1;
    localparam logic [16:0] E_BR1   = 17'b1_0_0_0_0_0_0_010_01_00_00_1;
    localparam logic [16:0] E_BR0   = 17'b1_0_0_0_0_0_0_010_00_00_00_1;
    localparam logic [16:0] E_JMP   = 17'b1_0_0_0_0_0_0_000_10_00_00_1;
    localparam logic [16:0] E_JAL   = 17'b1_0_0_0_1_0_0_000_10_10_10_1;
    localparam logic [16:0] E_NOP   = 17'b1_0_0_0_0_0_0_000_00_00_00_1;

    mccpu_ctrl #(.RESET_STATE_HOLD(1)) dut (
        .clk(clk), .rst(rst),
`ifdef MCCPU_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWr(PCWr), .IRWr(IRWr), .IorD(IorD), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel),
        .WDSel(WDSel), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (state !== 4'd15) begin errors++; $display("FAIL reset_state got %0d want 15", state); end
        checks++; if (outs !== 17'd0) begin errors++; $display("FAIL reset_outs got %b want 0", outs); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
        rst = 1'b0;
        #1;
        checks++; if (state !== 4'd15 || outs !== 17'd0) begin errors++; $display("FAIL idle_hold got st=%0d outs=%b want st=15 outs=0", state, outs); end
        tick();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL idle_exit got %0d want 0", state); end
        $display("reset: released, first fetch state=%0d", state);
    endtask

    task automatic test_rtype;
        logic [5:0]  fn[5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
        logic [16:0] ex[5] = '{E_ADDU, E_SUBU, E_AND, E_OR, E_SLT};
        logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [16:0] ev;
        for (int k = 0; k < 5; k++) begin
            Op = 6'b000000;
            Funct = fn[k];
            for (int i = 0; i < 4; i++) begin
                ev = (i == 0) ? E_FE : (i == 1) ? E_DCD : (i == 2) ? ex[k] : E_WB_R;
                checks++; if (state !== st[i]) begin errors++; $display("FAIL rtype%0d_state%0d got %0d want %0d", k, i, state, st[i]); end
                checks++; if (outs !== ev) begin errors++; $display("FAIL rtype%0d_outs%0d got %b want %b", k, i, outs, ev); end
                tick();
            end
            checks++; if (state !== 4'd0) begin errors++; $display("FAIL rtype%0d_return got %0d want 0", k, state); end
            $display("rtype funct=%b done", fn[k]);
        end
    endtask

    task automatic test_imm;
        logic [5:0]  op[2] = '{6'b001000, 6'b001101};
        logic [16:0] ex[2] = '{E_ADDI, E_ORI};
        logic [16:0] ev;
        for (int k = 0; k < 2; k++) begin
            Op = op[k];
            Funct = 6'b111111;
            for (int i = 0; i < 4; i++) begin
                ev = (i == 0) ? E_FE : (i == 1) ? E_DCD : (i == 2) ? ex[k] : E_WB_I;
                checks++; if (state !== 4'(i)) begin errors++; $display("FAIL imm%0d_state%0d got %0d want %0d", k, i, state, i); end
                checks++; if (outs !== ev) begin errors++; $display("FAIL imm%0d_outs%0d got %b want %b", k, i, outs, ev); end
                tick();
            end
            $display("imm op=%b done", op[k]);
        end
    endtask

    task automatic test_mem;
        logic [5:0]  op[9] = '{6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'b100011,
                               6'b101011, 6'b101011, 6'b101011, 6'b101011};
        logic [3:0]  st[9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd0, 4'd1, 4'd4, 4'd7};
        logic [16:0] ex[9] = '{E_FE, E_DCD, E_MADDR, E_MRD, E_MWB, E_FE, E_DCD, E_MADDR, E_MWR};
        Funct = 6'd0;
        for (int i = 0; i < 9; i++) begin
            Op = op[i];
            checks++; if (state !== st[i]) begin errors++; $display("FAIL mem_state%0d got %0d want %0d", i, state, st[i]); end
            checks++; if (outs !== ex[i]) begin errors++; $display("FAIL mem_outs%0d got %b want %b", i, outs, ex[i]); end
            if (i == 4) $display("lw done");
            tick();
        end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_return got %0d want 0", state); end
        $display("sw done");
    endtask

    task automatic test_branch_jump;
        logic [5:0]  op[9] = '{6'b000100, 6'b000100, 6'b000100, 6'b000100, 6'b000100, 6'b000100,
                               6'b000010, 6'b000010, 6'b000010};
        logic        zr[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0]  st[9] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
        logic [16:0] ex[9] = '{E_FE, E_DCD, E_BR1, E_FE, E_DCD, E_BR0, E_FE, E_DCD, E_JMP};
        for (int i = 0; i < 9; i++) begin
            Op = op[i];
            Zero = zr[i];
            #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL brj_state%0d got %0d want %0d", i, state, st[i]); end
            checks++; if (outs !== ex[i]) begin errors++; $display("FAIL brj_outs%0d got %b want %b", i, outs, ex[i]); end
            if (i % 3 == 2) $display("branch/jump op=%b zero=%b done", op[i], zr[i]);
            tick();
        end
        Zero = 1'b0;
    endtask

    task automatic test_jal_illegal;
        logic [5:0]  op[10] = '{6'b000011, 6'b000011, 6'b000011, 6'b111111, 6'b111111, 6'b111111,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000};
        logic [3:0]  st[10] = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd1, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3};
        logic [16:0] ex[10] = '{E_FE, E_DCD, E_JAL, E_FE, E_DCD, E_NOP, E_FE, E_DCD, E_ADDU, E_WB_R};
        logic        il[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        Funct = 6'b100001;
        for (int i = 0; i < 10; i++) begin
            Op = op[i];
            checks++; if (state !== st[i]) begin errors++; $display("FAIL jil_state%0d got %0d want %0d", i, state, st[i]); end
            checks++; if (outs !== ex[i]) begin errors++; $display("FAIL jil_outs%0d got %b want %b", i, outs, ex[i]); end
            checks++; if (illegal !== il[i]) begin errors++; $display("FAIL jil_illegal%0d got %b want %b", i, illegal, il[i]); end
            if (i == 2 || i == 5 || i == 9) $display("instr op=%b done illegal=%b", op[i], illegal);
            tick();
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] st[4] = '{4'd0, 4'd1, 4'd4, 4'd5};
        Op = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== st[i]) begin errors++; $display("FAIL rmid_state%0d got %0d want %0d", i, state, st[i]); end
            if (i < 3) tick();
        end
        rst = 1'b1;
        #1;
        checks++; if (state !== 4'd15) begin errors++; $display("FAIL rmid_async got %0d want 15", state); end
        checks++; if (outs !== 17'd0) begin errors++; $display("FAIL rmid_outs got %b want 0", outs); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rmid_illegal got %b want 0", illegal); end
        tick();
        checks++; if (state !== 4'd15) begin errors++; $display("FAIL rmid_held got %0d want 15", state); end
        rst = 1'b0;
        tick();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rmid_refetch got %0d want 0", state); end
        $display("reset mid-MRD: recovered to state=%0d", state);
    endtask

`ifdef MCCPU_MEM_WAIT_EN
    task automatic test_mem_wait;
        int irwr_cycles = 0;
        int cycles = 0;
        Op = 6'b100011;
        mem_ready = 1'b0;
        while (state == 4'd0 && cycles < 20) begin
            if (IRWr === 1'b1) irwr_cycles++;
            if (cycles == 3) mem_ready = 1'b1;
            #1;
            tick();
            cycles++;
        end
        checks++; if (irwr_cycles !== 4) begin errors++; $display("FAIL wait_irwr got %0d want 4", irwr_cycles); end
        while (state != 4'd5 && cycles < 20) begin tick(); cycles++; end
        mem_ready = 1'b0;
        tick(); cycles++;
        tick(); cycles++;
        checks++; if (state !== 4'd5 || IorD !== 1'b1) begin errors++; $display("FAIL wait_mrd got st=%0d iord=%b want 5 1", state, IorD); end
        mem_ready = 1'b1;
        while (state != 4'd0 && cycles < 30) begin tick(); cycles++; end
        checks++; if (cycles !== 10) begin errors++; $display("FAIL wait_lw_latency got %0d want 10", cycles); end
        Op = 6'b101011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        checks++; if (state !== 4'd7 || MemWrite !== 1'b1 || PCWr !== 1'b0 || instr_done !== 1'b0) begin
            errors++; $display("FAIL wait_mwr_stall got st=%0d mw=%b pcwr=%b done=%b", state, MemWrite, PCWr, instr_done); end
        mem_ready = 1'b1;
        #1;
        checks++; if (PCWr !== 1'b1 || instr_done !== 1'b1) begin errors++; $display("FAIL wait_mwr_go got pcwr=%b done=%b want 1 1", PCWr, instr_done); end
        tick();
        $display("mem wait: lw cycles=%0d irwr=%0d", cycles, irwr_cycles);
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_imm();
        test_mem();
        test_branch_jump();
        test_jal_illegal();
        test_reset_mid();
`ifdef MCCPU_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
